// File: rtl/shrg_frame.sv
// -----------------------------------------------------------------------------
// shrg_frame -- parametrised framed shift register.
//
// Deserialises serial bits into a parallel word, serialises a loaded word, or
// does both at once. It supports bidirectional shift, rotate and parallel load.
// A shift counter marks frames of N shifts/rotates with a one-cycle
// frame_done pulse.
//
// Optional build macro:
//   SHRG_AUTOLATCH_EN -- when defined, the edge that completes a frame also
//                        copies the post-shift buffer into o. This overrides
//                        a simultaneous set and is suppressed by clr.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   data       in   serial input bit
//   i          in   [N-1:0] parallel load word
//   mode       in   [1:0] 00 hold, 01 shift, 10 load, 11 rotate
//   dir        in   0 shifts toward the MSB, 1 shifts toward the LSB
//   clr        in   synchronous clear of buffer and counter
//   set        in   copy the pre-edge buffer into o
//   o          out  [N-1:0] latched parallel output (registered)
//   so         out  serial output: buf[N-1] (dir=0) or buf[0] (dir=1)
//   cnt        out  [CW-1:0] shifts/rotates in the current frame, 0..N-1
//   frame_done out  one-cycle pulse after the N-th shift/rotate of a frame
// -----------------------------------------------------------------------------
module shrg_frame #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          data,
  input  logic [N-1:0]  i,
  input  logic [1:0]    mode,
  input  logic          dir,
  input  logic          clr,
  input  logic          set,
  output logic [N-1:0]  o,
  output logic          so,
  output logic [CW-1:0] cnt,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_ROT   = 2'b11
  } mode_e;

  mode_e         mode_s;
  logic [N-1:0]  buf_q, buf_d;
  logic [N-1:0]  o_q, o_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          fill_bit;

  assign mode_s = mode_e'(mode);

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    o_d      = o_q;
    fill_bit = data;

    // set samples the pre-edge buffer regardless of mode or clr.
    if (set) o_d = buf_q;

    if (clr) begin
      buf_d = '0;
      cnt_d = '0;
    end else begin
      case (mode_s)
        MODE_HOLD: ;
        MODE_LOAD: begin
          buf_d = i;
          cnt_d = '0;
        end
        MODE_SHIFT, MODE_ROT: begin
          // Rotate feeds back the bit falling off the leading end.
          if (mode_s == MODE_ROT) fill_bit = dir ? buf_q[0] : buf_q[N-1];
          buf_d = dir ? {fill_bit, buf_q[N-1:1]} : {buf_q[N-2:0], fill_bit};
          if (cnt_q == CW'(N - 1)) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end

`ifdef SHRG_AUTOLATCH_EN
    // done_d is only raised when clr is low, so clr suppresses autolatch.
    if (done_d) o_d = buf_d;
`else
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q  <= '0;
      o_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      o_q    <= o_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign o          = o_q;
  assign cnt        = cnt_q;
  assign frame_done = done_q;
  assign so         = dir ? buf_q[0] : buf_q[N-1];

endmodule

// File: doc/shrg_frame.md
# shrg_frame

Parametrised framed shift register, the next generation of the team's `shrg` shift-register block. It adds configurable width, bidirectional shift, rotate, a shift counter with frame-done pulse, a serial output and an optional automatic output latch at frame boundaries. It sits between a serial pin interface (bit-banged or SPI-like) and parallel logic. It deserialises inbound bits into a parallel word, serialises a loaded word outbound, or does both at once.

## Interface
- `N`, 8, register width in bits, N ≥ 2.
- `CW`, `$clog2(N)`, counter width, derived; do not override.
- `clk` input 1: clock, all state updates on the rising edge.
- `reset` input 1: reset, asynchronous, active-low.
- `data` input 1: serial input bit.
- `i` input N: parallel load word.
- `mode` input 2: 00 hold, 01 shift, 10 parallel load, 11 rotate.
- `dir` input 1: 0 shifts toward the MSB; 1 shifts toward the LSB.
- `clr` input 1: synchronous clear of the buffer and counter.
- `set` input 1: copies the buffer into `o`.
- `o` output N: latched parallel output, registered.
- `so` output 1: serial output, combinational from the buffer.
- `cnt` output CW: number of shifts or rotates in the current frame, 0..N-1.
- `frame_done` output 1: one-cycle pulse when the N-th shift or rotate of a frame completes.

## Operation
- Internal state: `buf[N-1:0]`, `cnt`, `o`, `frame_done`.
- Priority on each rising edge: `clr`, then `mode`.
- `clr`=1: `buf` ← 0, `cnt` ← 0, `frame_done` ← 0. `o` is untouched, except that `set` is still honoured and samples the pre-edge `buf`.
- `mode` 00 (hold): `buf` and `cnt` unchanged.
- `mode` 01 (shift):
  - `dir`=0: `buf` ← {buf[N-2:0], data}.
  - `dir`=1: `buf` ← {data, buf[N-1:1]}.
- `mode` 11 (rotate):
  - `dir`=0: `buf` ← {buf[N-2:0], buf[N-1]}.
  - `dir`=1: `buf` ← {buf[0], buf[N-1:1]}.
- `mode` 10 (load): `buf` ← `i`, `cnt` ← 0, no `frame_done`.
- Counter:
  - Each shift or rotate increments `cnt`.
  - When `cnt`==N-1 at the edge, `cnt` wraps to 0 and `frame_done` is 1 for the following cycle. Otherwise `frame_done` is 0.
  - `dir` may change mid-frame; the count continues.
- `so`: buf[N-1] when `dir`=0, buf[0] when `dir`=1. It reflects the current `buf` and `dir` with no register.
- `set`=1: `o` ← pre-edge `buf`, independent of `mode`.
- Reset (`reset`=0, asynchronous): `buf`=0, `o`=0, `cnt`=0, `frame_done`=0, hence `so`=0. Reset mid-frame discards the partial frame. The first edge after release is a normal cycle.

## Timing
- `o`, `cnt`, `frame_done`: registered; they update one edge after their cause.
- Shift latency: a bit on `data` at edge k is in `buf` after edge k and visible on `so` after edge k+N-1 (edge k itself counts as shift 1 of N).
- Frame of N consecutive shifts starting at `cnt`=0: `frame_done` is high in the cycle after the N-th edge.
- Hold cycles inside a frame extend the frame; there is no timeout.
- `set` coincident with a frame-completing shift: `o` receives the pre-shift `buf`. With autolatch compiled in, autolatch wins (see Configuration).
- `reset` is asserted asynchronously. Its release must be synchronised to `clk` externally.

## Configuration
- `SHRG_AUTOLATCH_EN` defined: on the edge that completes a frame, `o` ← post-shift `buf` (the same value `buf` takes on that edge). This overrides a simultaneous `set`. Suppressed when `clr`=1.
- Not defined: `o` changes only on `set` or reset. `frame_done` behaviour is identical in both builds.

## Test plan
- Reset then load: N=8, reset low, check `o`=0x00, `cnt`=0, `so`=0. Release, `mode`=10 with `i`=0xA5, then `set`=1 for one cycle. Required: `o`=0xA5, `cnt`=0.
- MSB-first deserialise: `dir`=0, shift in bits 1,0,1,1,0,0,1,0. Required: `buf`=0xB2, `frame_done` high for exactly one cycle after the 8th edge, `cnt` back to 0. With autolatch, `o`=0xB2 on the same edge; without it, `o` unchanged.
- LSB-first serialise: load 0x3C, `dir`=1, `data`=0, shift 8 edges. Required `so` sequence, sampled before each edge: 0,0,1,1,1,1,0,0. Final `buf`=0x00.
- Rotate and direction change: load 0x81, rotate `dir`=0 for 1 edge, giving 0x03. Then rotate `dir`=1 for 2 edges, giving 0x81 then 0xC0. `cnt`=3 and no `frame_done`.
- Priority: `buf`=0xFF, `cnt`=5. Apply `clr`=1 with `mode`=01 and `set`=1 on the same edge. Required: `buf`=0, `cnt`=0, `o`=0xFF (pre-edge `buf`), `frame_done`=0.
- Reset mid-frame: after 4 shifts, pulse `reset` low between edges. Required: all state 0 immediately without waiting for a clock edge. A subsequent 8-shift frame counts from 0 and pulses `frame_done` after its 8th edge.
